// File: rtl/register_file.sv
// Per-thread 16 x 8-bit register file for one SIMT lane: two registered read ports, one write port.
// Optional REG_ZERO_R0_EN: R0 hardwired to zero (writes dropped, reads return 0).
module register_file #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    parameter int DATA_BITS         = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 reg_write_enable,
    input  logic [1:0]           reg_input_mux,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic [DATA_BITS-1:0] lsu_out,
    input  logic [DATA_BITS-1:0] immediate,
    input  logic [3:0]           rs_address,
    input  logic [3:0]           rt_address,
    input  logic [3:0]           rd_address,
    input  logic [DATA_BITS-1:0] block_id,
    output logic [DATA_BITS-1:0] rs_data,
    output logic [DATA_BITS-1:0] rt_data
);

    localparam logic [2:0] STATE_REQUEST = 3'b011;
    localparam logic [2:0] STATE_UPDATE  = 3'b110;
    localparam int         NUM_GPR       = 13;

    localparam logic [DATA_BITS-1:0] BLOCK_DIM = DATA_BITS'(THREADS_PER_BLOCK);
    localparam logic [DATA_BITS-1:0] THREAD_IX = DATA_BITS'(THREAD_ID);

    logic [DATA_BITS-1:0] w_regs [0:15];
    logic [DATA_BITS-1:0] w_write_data;
    logic                 w_write_en;
    logic                 w_read_en;
    logic [DATA_BITS-1:0] r_block_id;
    logic [DATA_BITS-1:0] r_rs_data;
    logic [DATA_BITS-1:0] r_rt_data;

    always_comb begin
        w_write_data = alu_out;
        case (reg_input_mux)
            2'b00:   w_write_data = alu_out;
            2'b01:   w_write_data = lsu_out;
            2'b10:   w_write_data = immediate;
            default: w_write_data = alu_out;
        endcase
    end

    // Only R0..R12 are writable; the mux code 11 means "no writeback".
`ifdef REG_ZERO_R0_EN
    assign w_write_en = enable && (core_state == STATE_UPDATE) && reg_write_enable &&
                        (rd_address <= 4'd12) && (rd_address != 4'd0) &&
                        (reg_input_mux != 2'b11);
`else
    assign w_write_en = enable && (core_state == STATE_UPDATE) && reg_write_enable &&
                        (rd_address <= 4'd12) && (reg_input_mux != 2'b11);
`endif

    assign w_read_en = enable && (core_state == STATE_REQUEST);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_GPR; gi++) begin : g_gpr
            logic [DATA_BITS-1:0] r_value;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_value <= '0;
                end else if (w_write_en && (rd_address == 4'(gi))) begin
                    r_value <= w_write_data;
                end
            end

`ifdef REG_ZERO_R0_EN
            if (gi == 0) begin : g_zero
                assign w_regs[gi] = '0;
            end else begin : g_live
                assign w_regs[gi] = r_value;
            end
`else
            assign w_regs[gi] = r_value;
`endif
        end
    endgenerate

    // R13 tracks block_id on every enabled edge, regardless of core state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_block_id <= '0;
        end else if (enable) begin
            r_block_id <= block_id;
        end
    end

    assign w_regs[13] = r_block_id;
    assign w_regs[14] = BLOCK_DIM;
    assign w_regs[15] = THREAD_IX;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rs_data <= '0;
            r_rt_data <= '0;
        end else if (w_read_en) begin
            r_rs_data <= w_regs[rs_address];
            r_rt_data <= w_regs[rt_address];
        end
    end

    assign rs_data = r_rs_data;
    assign rt_data = r_rt_data;

endmodule

// File: tb/tb_register_file.sv
// Directed-vector bench for register_file: table of per-cycle stimulus with expected read outputs.
module tb_register_file;

    localparam int TPB = 4;
    localparam int TID = 2;

`ifdef REG_ZERO_R0_EN
    localparam logic [7:0] R0_EXP = 8'h00;
`else
    localparam logic [7:0] R0_EXP = 8'hFF;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic       reg_write_enable;
    logic [1:0] reg_input_mux;
    logic [7:0] alu_out, lsu_out, immediate, block_id;
    logic [3:0] rs_address, rt_address, rd_address;
    logic [7:0] rs_data, rt_data;

    int n_checks = 0;
    int n_fails  = 0;

    register_file #(
        .THREADS_PER_BLOCK(TPB),
        .THREAD_ID(TID),
        .DATA_BITS(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .core_state(core_state),
        .reg_write_enable(reg_write_enable),
        .reg_input_mux(reg_input_mux),
        .alu_out(alu_out),
        .lsu_out(lsu_out),
        .immediate(immediate),
        .rs_address(rs_address),
        .rt_address(rt_address),
        .rd_address(rd_address),
        .block_id(block_id),
        .rs_data(rs_data),
        .rt_data(rt_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       en;
        logic [2:0] st;
        logic       we;
        logic [1:0] mux;
        logic [7:0] alu;
        logic [7:0] lsu;
        logic [7:0] imm;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [3:0] rd;
        logic [7:0] blk;
        logic [7:0] ers;
        logic [7:0] ert;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic en, logic [2:0] st, logic we, logic [1:0] mux,
                                logic [7:0] alu, logic [7:0] lsu, logic [7:0] imm,
                                logic [3:0] rs, logic [3:0] rt, logic [3:0] rd,
                                logic [7:0] blk, logic [7:0] ers, logic [7:0] ert);
        vec_t v;
        v.en = en; v.st = st; v.we = we; v.mux = mux;
        v.alu = alu; v.lsu = lsu; v.imm = imm;
        v.rs = rs; v.rt = rt; v.rd = rd; v.blk = blk;
        v.ers = ers; v.ert = ert;
        return v;
    endfunction

    function automatic vec_t rd_v(logic [3:0] rs, logic [3:0] rt, logic [7:0] blk,
                                  logic [7:0] ers, logic [7:0] ert);
        return mk(1'b1, 3'b011, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, rs, rt, 4'd0, blk, ers, ert);
    endfunction

    function automatic vec_t wr_v(logic [3:0] rd, logic [1:0] mux, logic [7:0] alu,
                                  logic [7:0] lsu, logic [7:0] imm,
                                  logic [7:0] ers, logic [7:0] ert);
        return mk(1'b1, 3'b110, 1'b1, mux, alu, lsu, imm, 4'd0, 4'd0, rd, 8'hAA, ers, ert);
    endfunction

    task automatic drive(vec_t v);
        enable           = v.en;
        core_state       = v.st;
        reg_write_enable = v.we;
        reg_input_mux    = v.mux;
        alu_out          = v.alu;
        lsu_out          = v.lsu;
        immediate        = v.imm;
        rs_address       = v.rs;
        rt_address       = v.rt;
        rd_address       = v.rd;
        block_id         = v.blk;
    endtask

    task automatic check(string name, logic [7:0] got, logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    initial begin
        vec_t v;
        // Power-on reads and reserved registers
        vecs.push_back(rd_v(4'd0,  4'd0,  8'hAA, 8'h00, 8'h00));
        vecs.push_back(rd_v(4'd14, 4'd15, 8'hAA, 8'(TPB), 8'(TID)));
        vecs.push_back(rd_v(4'd13, 4'd13, 8'hAA, 8'hAA, 8'hAA));
        // Writes from each source; outputs hold between reads
        vecs.push_back(wr_v(4'd5, 2'b00, 8'h0F, 8'h11, 8'h22, 8'hAA, 8'hAA));
        vecs.push_back(rd_v(4'd5, 4'd5, 8'hAA, 8'h0F, 8'h0F));
        vecs.push_back(wr_v(4'd6, 2'b01, 8'h55, 8'hF0, 8'h77, 8'h0F, 8'h0F));
        vecs.push_back(rd_v(4'd6, 4'd5, 8'hAA, 8'hF0, 8'h0F));
        vecs.push_back(wr_v(4'd7, 2'b10, 8'h55, 8'h66, 8'hA5, 8'hF0, 8'h0F));
        vecs.push_back(rd_v(4'd7, 4'd6, 8'hAA, 8'hA5, 8'hF0));
        // Protected targets and mux = 11
        vecs.push_back(wr_v(4'd13, 2'b00, 8'h55, 8'h55, 8'h55, 8'hA5, 8'hF0));
        vecs.push_back(wr_v(4'd14, 2'b00, 8'h55, 8'h55, 8'h55, 8'hA5, 8'hF0));
        vecs.push_back(wr_v(4'd15, 2'b00, 8'h55, 8'h55, 8'h55, 8'hA5, 8'hF0));
        vecs.push_back(wr_v(4'd4,  2'b11, 8'h55, 8'h55, 8'h55, 8'hA5, 8'hF0));
        vecs.push_back(rd_v(4'd13, 4'd14, 8'hAA, 8'hAA, 8'(TPB)));
        vecs.push_back(rd_v(4'd15, 4'd4,  8'hAA, 8'(TID), 8'h00));
        // enable = 0: no write, no read, no block_id mirror
        vecs.push_back(mk(1'b0, 3'b110, 1'b1, 2'b00, 8'h33, 8'h33, 8'h33, 4'd3, 4'd5, 4'd3, 8'hAA, 8'(TID), 8'h00));
        vecs.push_back(mk(1'b0, 3'b011, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 4'd3, 4'd5, 4'd0, 8'hBB, 8'(TID), 8'h00));
        vecs.push_back(rd_v(4'd3,  4'd5,  8'hAA, 8'h00, 8'h0F));
        vecs.push_back(rd_v(4'd5,  4'd7,  8'hAA, 8'h0F, 8'hA5));
        vecs.push_back(rd_v(4'd13, 4'd13, 8'hAA, 8'hAA, 8'hAA));
        // Write request in a non-UPDATE state is ignored
        vecs.push_back(mk(1'b1, 3'b000, 1'b1, 2'b00, 8'h99, 8'h99, 8'h99, 4'd0, 4'd0, 4'd8, 8'hAA, 8'hAA, 8'hAA));
        vecs.push_back(rd_v(4'd8,  4'd7,  8'hAA, 8'h00, 8'hA5));
        // R0 write (hardwired zero when the option is built in)
        vecs.push_back(wr_v(4'd0,  2'b00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hA5));
        vecs.push_back(rd_v(4'd0,  4'd0,  8'hAA, R0_EXP, R0_EXP));
        // Mirror picks up a new block_id in any state
        vecs.push_back(mk(1'b1, 3'b000, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 4'd0, 4'd0, 4'd0, 8'h5C, R0_EXP, R0_EXP));
        vecs.push_back(rd_v(4'd13, 4'd13, 8'h5C, 8'h5C, 8'h5C));
        // UPDATE without write enable
        vecs.push_back(mk(1'b1, 3'b110, 1'b0, 2'b00, 8'h77, 8'h77, 8'h77, 4'd0, 4'd0, 4'd9, 8'h5C, 8'h5C, 8'h5C));
        vecs.push_back(rd_v(4'd9,  4'd9,  8'h5C, 8'h00, 8'h00));

        reset = 1'b0;
        drive(rd_v(4'd0, 4'd0, 8'hAA, 8'h00, 8'h00));
        #15;
        check("reset rs_data", rs_data, 8'h00);
        check("reset rt_data", rt_data, 8'h00);
        #5 reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i]);
            @(posedge clock);
            @(negedge clock);
            check($sformatf("vec%0d rs_data", i), rs_data, vecs[i].ers);
            check($sformatf("vec%0d rt_data", i), rt_data, vecs[i].ert);
        end

        // Async reset mid-cycle clears outputs without a clock edge
        v = rd_v(4'd5, 4'd7, 8'hAA, 8'h0F, 8'hA5);
        drive(v);
        @(posedge clock);
        @(negedge clock);
        check("pre-reset rs_data", rs_data, 8'h0F);
        check("pre-reset rt_data", rt_data, 8'hA5);
        #2 reset = 1'b0;
        #1;
        check("async reset rs_data", rs_data, 8'h00);
        check("async reset rt_data", rt_data, 8'h00);
        @(negedge clock);
        reset = 1'b1;
        drive(rd_v(4'd5, 4'd14, 8'hAA, 8'h00, 8'h00));
        @(posedge clock);
        @(negedge clock);
        check("post-reset R5", rs_data, 8'h00);
        check("post-reset R14", rt_data, 8'(TPB));
        drive(wr_v(4'd9, 2'b00, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00));
        @(posedge clock);
        @(negedge clock);
        drive(rd_v(4'd9, 4'd13, 8'hAA, 8'h00, 8'h00));
        @(posedge clock);
        @(negedge clock);
        check("post-reset write R9", rs_data, 8'h3C);
        check("post-reset R13", rt_data, 8'hAA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Per-thread 16 x 8-bit register file for one SIMT thread lane of the mini-GPU compute core.
- Provides two read ports (rs, rt), sampled in the core's REQUEST state.
- Provides one write port (rd), committed in the core's UPDATE state, with data selected from ALU, LSU or immediate.
- R13..R15 are reserved: R13 = block id, R14 = block dimension, R15 = thread id.

Parameters:
- THREADS_PER_BLOCK, 4, constant value presented in R14 (block dimension).
- THREAD_ID, 0, constant value presented in R15 (this lane's thread index).
- DATA_BITS, 8, register and datapath width.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  lane active; when 0, all registers and outputs hold.
- core_state  input  3  core FSM state; 3'b011 = REQUEST (read), 3'b110 = UPDATE (write); other codes are ignored.
- reg_write_enable  input  1  destination-write request from the decoder.
- reg_input_mux  input  2  write source select: 00 ALU, 01 LSU, 10 immediate, 11 none.
- alu_out  input  8  ALU result.
- lsu_out  input  8  load/store unit result.
- immediate  input  8  decoded instruction immediate.
- rs_address  input  4  source register 1 index.
- rt_address  input  4  source register 2 index.
- rd_address  input  4  destination register index.
- block_id  input  8  current block index, mirrored into R13.
- rs_data  output  8  registered read data for rs.
- rt_data  output  8  registered read data for rt.

Behaviour:
- Reset (reset low, asynchronous):
  - R0..R12 and R13 cleared to 0.
  - R14 loaded with THREADS_PER_BLOCK; R15 loaded with THREAD_ID.
  - rs_data and rt_data cleared to 0.
- enable = 0: no register or output changes, regardless of core_state.
- Block id mirror: every rising edge with enable = 1, R13 <= block_id, independent of core_state and reg_write_enable.
- Read, core_state = 3'b011 and enable = 1:
  - rs_data <= R[rs_address] and rt_data <= R[rt_address] on that edge.
  - Outputs are valid one clock after the edge and hold until the next REQUEST edge.
  - Reads return the pre-edge register contents; no same-edge write forwarding.
- Write, core_state = 3'b110 and enable = 1 and reg_write_enable = 1 and rd_address <= 12:
  - R[rd_address] <= selected source: alu_out / lsu_out / immediate per reg_input_mux.
  - reg_input_mux = 11: no write.
- Protected registers: writes targeting rd_address 13, 14 or 15 are silently dropped. R14 and R15 are constant after reset. R13 changes only via the block_id mirror.
- Read and write states are mutually exclusive, so a simultaneous read and write cannot occur. The rs and rt ports may address the same register.
- Reset asserted mid-operation overrides everything immediately; the first write after deassertion follows the normal rules.
- All widths are exactly 8 bits; no arithmetic is performed inside the block.

Optional Feature:
- Macro REG_ZERO_R0_EN.
- Defined: R0 is hardwired to zero; writes to rd_address 0 are dropped and reads of R0 always return 8'h00.
- Undefined: R0 is an ordinary writable general-purpose register.

Test Plan:
- Reset low 20 ns, then release, hold core_state = 011 on rs = rt = 0 -> rs_data = rt_data = 8'h00; reading R14 returns THREADS_PER_BLOCK and R15 returns THREAD_ID.
- enable = 1, block_id = 8'hAA, one clock; then core_state = 011, rs_address = 13 -> rs_data = 8'hAA one clock later.
- core_state = 110, rd = 5, mux = 00, alu_out = 8'h0F, write_enable = 1; then read rs = 5 -> 8'h0F. Repeat rd = 6, mux = 01, lsu_out = 8'hF0 -> 8'hF0. Repeat rd = 7, mux = 10, immediate = 8'hA5 -> 8'hA5.
- Write attempts to R13/R14/R15 with alu_out = 8'h55 -> reads still return block_id / THREADS_PER_BLOCK / THREAD_ID. Same write with mux = 11 to R4 -> R4 unchanged.
- enable = 0 with core_state = 110 writing 8'h33 to R3, and with core_state = 011 -> R3 and rs_data/rt_data unchanged.
- Dual read rs = 5, rt = 7 -> rs_data = 8'h0F, rt_data = 8'hA5 same cycle. Reset asserted mid-sequence -> all outputs 0 asynchronously. With REG_ZERO_R0_EN defined, write 8'hFF to R0 -> read returns 8'h00.
